// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-operand forwarding select and load-use interlock.
// A load-use hazard holds fetch/decode for LOAD_USE_STALL cycles while bubbles enter ID/EX.
module id_ex_stage #(
  parameter int LOAD_USE_STALL = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      dec_ir,
  input  logic [31:0]      dec_pc,
  input  logic [31:0]      dec_rs1_val,
  input  logic [31:0]      dec_rs2_val,
  input  logic             flush,
  input  logic [1:0]       f_rs1,
  input  logic [1:0]       f_rs2,
  input  logic [31:0]      fwd_1,
  input  logic [31:0]      fwd_2,
  output logic [31:0]      id_ex_ir,
  output logic [31:0]      id_ex_pc,
  output logic [31:0]      ex_op_a,
  output logic [31:0]      ex_op_b,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic {RUN, LU_STALL} state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] REM_INIT  = 3'(LOAD_USE_STALL - 1);

  state_t      state, state_nxt;
  logic [2:0]  rem, rem_nxt;
  logic [31:0] rs1_p1, rs2_p1;
  logic        hz, load_bubble;
  logic [4:0]  ld_rd;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A bubble in ID/EX carries opcode 0, so hz self-clears once the load has moved on.
  assign ld_rd = id_ex_ir[11:7];
  assign hz    = (id_ex_ir[6:0] == OP_LOAD) && (ld_rd != 5'd0) &&
                 (((ld_rd == dec_ir[19:15]) && uses_rs1(dec_ir[6:0])) ||
                  ((ld_rd == dec_ir[24:20]) && uses_rs2(dec_ir[6:0])));

  // Stage boundary: interlock FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      rem   <= 3'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    if (flush) begin
      state_nxt = RUN;
      rem_nxt   = 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (hz && (LOAD_USE_STALL > 1)) begin
            state_nxt = LU_STALL;
            rem_nxt   = REM_INIT;
          end
        end
        LU_STALL: begin
          rem_nxt = rem - 3'd1;
          if (rem == 3'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    stall       = !flush && ((state == LU_STALL) || hz);
    load_bubble = flush || stall;
  end

  // Stage boundary: ID/EX register and bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_ir   <= '0;
      id_ex_pc   <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      bubble_cnt <= '0;
    end else begin
      if (load_bubble) begin
        id_ex_ir <= '0;
        id_ex_pc <= '0;
        rs1_p1   <= '0;
        rs2_p1   <= '0;
      end else begin
        id_ex_ir <= dec_ir;
        id_ex_pc <= dec_pc;
        rs1_p1   <= dec_rs1_val;
        rs2_p1   <= dec_rs2_val;
      end
      if (stall) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  // Stage boundary: forwarding-resolved execute operands
  always_comb begin
    ex_op_a = (f_rs1 != 2'b00) ? fwd_1 : rs1_p1;
    ex_op_b = (f_rs2 != 2'b00) ? fwd_2 : rs2_p1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes model expectations, a negedge monitor checks them.
module tb_id_ex_stage;
  localparam int L  = 2;
  localparam int CW = 2;

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_DEP = 32'h00728333;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_X0  = 32'h00700333;
  localparam logic [31:0] JAL_X5  = 32'h005282EF;
  localparam logic [31:0] ADDI_R5 = 32'h00508313;
  localparam logic [31:0] ADD_X3  = 32'h002081B3;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   dec_ir, dec_pc, dec_rs1_val, dec_rs2_val;
  logic          flush;
  logic [1:0]    f_rs1, f_rs2;
  logic [31:0]   fwd_1, fwd_2;
  logic [31:0]   id_ex_ir, id_ex_pc, ex_op_a, ex_op_b;
  logic          stall;
  logic [CW-1:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.LOAD_USE_STALL(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .dec_ir(dec_ir), .dec_pc(dec_pc),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val), .flush(flush),
    .f_rs1(f_rs1), .f_rs2(f_rs2), .fwd_1(fwd_1), .fwd_2(fwd_2),
    .id_ex_ir(id_ex_ir), .id_ex_pc(id_ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic [31:0] ir, pc, a, b, cnt;
    logic        stl;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;

  // Reference state: what ID/EX holds, how many more stall cycles are owed, bubble total.
  logic [31:0] m_ir, m_pc, m_r1, m_r2;
  int          m_pend, m_cnt;
  logic        last_stall;

  function automatic bit rs1_used(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit rs2_used(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic bit model_hz(input logic [31:0] d);
    logic [4:0] rd;
    rd = m_ir[11:7];
    return (m_ir[6:0] == 7'h03) && (rd != 0) &&
           ((rd == d[19:15] && rs1_used(d[6:0])) || (rd == d[24:20] && rs2_used(d[6:0])));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ir = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_pend = 0; m_cnt = 0; last_stall = 0;
  endtask

  // Called at posedge+1; applies inputs for one cycle and returns at the next posedge+1.
  task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic fl, input logic [1:0] fr1,
                       input logic [1:0] fr2, input logic [31:0] f1, input logic [31:0] f2);
    exp_t e;
    bit   stl;
    dec_ir = ir; dec_pc = pc; dec_rs1_val = r1; dec_rs2_val = r2;
    flush = fl; f_rs1 = fr1; f_rs2 = fr2; fwd_1 = f1; fwd_2 = f2;
    stl   = !fl && (m_pend > 0 || model_hz(ir));
    e.ir  = m_ir;
    e.pc  = m_pc;
    e.a   = (fr1 != 0) ? f1 : m_r1;
    e.b   = (fr2 != 0) ? f2 : m_r2;
    e.cnt = 32'(m_cnt);
    e.stl = stl;
    q.push_back(e);
    last_stall = stl;
    @(posedge clk);
    if (fl) begin
      m_ir = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_pend = 0;
    end else if (stl) begin
      m_ir = 0; m_pc = 0; m_r1 = 0; m_r2 = 0;
      if (m_pend > 0) m_pend--;
      else m_pend = L - 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      m_ir = ir; m_pc = pc; m_r1 = r1; m_r2 = r2;
    end
    #1;
  endtask

  task automatic run(input logic [31:0] ir, input logic fl = 1'b0);
    drive(ir, 32'h100, 32'h5555, 32'h6666, fl, 2'b00, 2'b00, $urandom, $urandom);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    flush = 0; f_rs1 = 0; f_rs2 = 0;
    #2 rst = 1'b1;
    #1;
    check("rst_ir", id_ex_ir, 0);
    check("rst_pc", id_ex_pc, 0);
    check("rst_cnt", 32'(bubble_cnt), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_op_a", ex_op_a, 0);
    check("rst_op_b", ex_op_b, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [6:0]  ops[10];
    ops = '{7'h03, 7'h03, 7'h03, 7'h33, 7'h13, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h00};
    r       = $urandom;
    r[6:0]  = ops[$urandom_range(0, 9)];
    r[11:7] = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("id_ex_ir", id_ex_ir, mon_e.ir);
      check("id_ex_pc", id_ex_pc, mon_e.pc);
      check("ex_op_a", ex_op_a, mon_e.a);
      check("ex_op_b", ex_op_b, mon_e.b);
      check("stall", 32'(stall), 32'(mon_e.stl));
      check("bubble_cnt", 32'(bubble_cnt), mon_e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] cur_ir, cur_pc, cur_r1, cur_r2;
    rst = 1'b1;
    dec_ir = 0; dec_pc = 0; dec_rs1_val = 0; dec_rs2_val = 0;
    flush = 0; f_rs1 = 0; f_rs2 = 0; fwd_1 = 0; fwd_2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(ADD_X3);
    check("first_capture", id_ex_ir, ADD_X3);

    do_reset();
    run(LW_X5);
    repeat (3) run(ADD_DEP);
    check("lu_entry", id_ex_ir, ADD_DEP);
    check("lu_cnt", 32'(bubble_cnt), 2);

    do_reset();
    run(LW_X0); run(ADD_X0);
    run(LW_X5); run(JAL_X5);
    run(LW_X5); run(ADDI_R5);
    check("nohz_cnt", 32'(bubble_cnt), 0);

    do_reset();
    run(LW_X5); run(ADD_DEP); run(ADD_DEP, 1'b1);
    check("flush_ir", id_ex_ir, 0);
    check("flush_cnt", 32'(bubble_cnt), 1);
    run(ADD_X3);
    check("flush_resume", id_ex_ir, ADD_X3);

    run(LW_X5); run(ADD_DEP);
    do_reset();

    drive(ADD_X3, 32'h40, 32'h11, 32'h22, 0, 2'b00, 2'b00, 32'hAA, 32'hBB);
    for (int f = 0; f < 4; f++)
      drive(ADD_X3, 32'h40, 32'h11, 32'h22, 0, 2'(f), 2'(f), 32'hAA, 32'hBB);

    do_reset();
    for (int k = 0; k < 5; k++) begin
      run(LW_X5);
      repeat (3) run(ADD_DEP);
    end
    check("sat_cnt", 32'(bubble_cnt), 3);

    do_reset();
    cur_ir = 0; cur_pc = 0; cur_r1 = 0; cur_r2 = 0;
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      if (!last_stall) begin
        cur_ir = rand_ir(); cur_pc = $urandom; cur_r1 = $urandom; cur_r2 = $urandom;
      end
      drive(cur_ir, cur_pc, cur_r1, cur_r2, ($urandom_range(0, 15) == 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom);
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
